aim_noc_network_interface: RTL and testbench

//   Local-port network interface for AIM_NoC_Router. TX: packetises a core word stream

---
 rtl/aim_noc_network_interface.sv | 187 ++++++++++++++++++
 tb/tb_aim_noc_network_interface.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aim_noc_network_interface.sv
// Local-port network interface between a mesh node's core and its NoC router.
// TX packetises core words into HEAD/BODY/TAIL flits; RX depacketises into a buffered stream.
module aim_noc_network_interface #(
    parameter int unsigned FLIT_W    = 64,
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned MY_X      = 0,
    parameter int unsigned MY_Y      = 0,
    parameter int unsigned RX_DEPTH  = 8,
    localparam int unsigned PAYLOAD_W = FLIT_W - 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [PAYLOAD_W-1:0] tx_data,
    input  logic                 tx_last,
    input  logic [COORD_W-1:0]   tx_dest_x,
    input  logic [COORD_W-1:0]   tx_dest_y,
    input  logic                 inj_stall,
    output logic [FLIT_W-1:0]    local_in,
    input  logic [FLIT_W-1:0]    local_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [PAYLOAD_W-1:0] rx_data,
    output logic                 rx_last,
    output logic [COORD_W-1:0]   rx_src_x,
    output logic [COORD_W-1:0]   rx_src_y,
    output logic                 rx_overflow,
    output logic                 rx_err,
    output logic [15:0]          tx_pkt_cnt,
    output logic [15:0]          rx_pkt_cnt
);

    localparam int unsigned AW       = $clog2(RX_DEPTH);
    localparam int unsigned PTR_W    = AW + 1;
    localparam int unsigned HEAD_PAD = PAYLOAD_W - 4 * COORD_W;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic [0:0] {TX_IDLE, TX_BODY} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_PKT, RX_DISCARD} rx_state_t;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] data;
        logic                 last;
        logic [COORD_W-1:0]   src_x;
        logic [COORD_W-1:0]   src_y;
    } rx_entry_t;

    tx_state_t tx_state;
    rx_state_t rx_state;

    // ---------------- TX ----------------
    assign tx_ready = (tx_state == TX_BODY) && !inj_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state   <= TX_IDLE;
            local_in   <= '0;
            tx_pkt_cnt <= '0;
        end else begin
            local_in <= '0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid && !inj_stall) begin
                        local_in <= {1'b1, T_HEAD, tx_dest_x, tx_dest_y,
                                     COORD_W'(MY_X), COORD_W'(MY_Y), {HEAD_PAD{1'b0}}};
                        tx_state <= TX_BODY;
                    end
                end
                TX_BODY: begin
                    if (tx_valid && tx_ready) begin
                        local_in <= {1'b1, (tx_last ? T_TAIL : T_BODY), tx_data};
                        if (tx_last) begin
                            tx_state <= TX_IDLE;
                            if (tx_pkt_cnt != 16'hFFFF) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- RX flit decode ----------------
    logic                 flit_v;
    logic [1:0]           flit_type;
    logic [PAYLOAD_W-1:0] flit_field;
    logic [COORD_W-1:0]   hd_dx, hd_dy, hd_sx, hd_sy;
    logic                 is_head, is_data, is_tail, head_for_me;

    assign flit_v      = local_out[FLIT_W-1];
    assign flit_type   = local_out[FLIT_W-2 -: 2];
    assign flit_field  = local_out[PAYLOAD_W-1:0];
    assign hd_dx       = flit_field[PAYLOAD_W-1 -: COORD_W];
    assign hd_dy       = flit_field[PAYLOAD_W-1-COORD_W -: COORD_W];
    assign hd_sx       = flit_field[PAYLOAD_W-1-2*COORD_W -: COORD_W];
    assign hd_sy       = flit_field[PAYLOAD_W-1-3*COORD_W -: COORD_W];
    assign is_head     = flit_v && (flit_type == T_HEAD);
    assign is_tail     = flit_v && (flit_type == T_TAIL);
    assign is_data     = flit_v && ((flit_type == T_BODY) || (flit_type == T_TAIL));
    assign head_for_me = (hd_dx == COORD_W'(MY_X)) && (hd_dy == COORD_W'(MY_Y));

    // ---------------- RX FIFO ----------------
    rx_entry_t          fifo_mem [RX_DEPTH];
    rx_entry_t          head_entry;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [COORD_W-1:0] src_x_q, src_y_q;
    logic               full, push, pop, push_ok;

    assign rx_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = rx_valid && rx_ready;
    assign push     = (rx_state == RX_PKT) && is_data;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop);

    assign head_entry = fifo_mem[rd_ptr[AW-1:0]];
    assign rx_data    = head_entry.data;
    assign rx_last    = head_entry.last;
    assign rx_src_x   = head_entry.src_x;
    assign rx_src_y   = head_entry.src_y;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{data: flit_field, last: is_tail,
                                         src_x: src_x_q, src_y: src_y_q};
        end
    end

    // ---------------- RX FSM, pointers and status ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state    <= RX_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            rx_overflow <= 1'b0;
            rx_err      <= 1'b0;
            rx_pkt_cnt  <= '0;
        end else begin
            rx_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (is_head) begin
                        if (head_for_me) begin
                            src_x_q  <= hd_sx;
                            src_y_q  <= hd_sy;
                            rx_state <= RX_PKT;
                        end else begin
                            rx_err   <= 1'b1;
                            rx_state <= RX_DISCARD;
                        end
                    end else if (is_data) begin
                        rx_err <= 1'b1;
                    end
                end
                RX_PKT: begin
                    // A new HEAD mid-packet is an error but restarts capture from it.
                    if (is_head) begin
                        rx_err <= 1'b1;
                        if (head_for_me) begin
                            src_x_q <= hd_sx;
                            src_y_q <= hd_sy;
                        end else begin
                            rx_state <= RX_DISCARD;
                        end
                    end else if (is_tail) begin
                        rx_state <= RX_IDLE;
                        if (push_ok && rx_pkt_cnt != 16'hFFFF) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
                    end
                end
                RX_DISCARD: begin
                    if (is_tail) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase

            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !push_ok) rx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aim_noc_network_interface.sv
// Self-checking bench for aim_noc_network_interface: vector table, hand sequences
// and randomized TX/RX traffic against a flit-level reference model.
module tb_aim_noc_network_interface;

    localparam int unsigned DEPTH = 8;
    localparam int          NPK   = 40;
    localparam int          M_IDLE = 0, M_PKT = 1, M_DROP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid, tx_ready, tx_last, inj_stall;
    logic [60:0] tx_data;
    logic [3:0]  tx_dest_x, tx_dest_y;
    logic [63:0] local_in, local_out;
    logic        rx_valid, rx_ready, rx_last, rx_overflow, rx_err;
    logic [60:0] rx_data;
    logic [3:0]  rx_src_x, rx_src_y;
    logic [15:0] tx_pkt_cnt, rx_pkt_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aim_noc_network_interface #(
        .FLIT_W(64), .COORD_W(4), .MY_X(0), .MY_Y(0), .RX_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .inj_stall(inj_stall),
        .local_in(local_in), .local_out(local_out),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
        .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_overflow(rx_overflow), .rx_err(rx_err),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt)
    );

    typedef struct {
        logic        valid;
        logic [60:0] data;
        logic        last;
        logic        stall;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic        exp_ready;
        logic [63:0] exp_flit;
    } tx_vec_t;

    typedef struct {
        logic [60:0] d;
        logic        l;
        logic [3:0]  sx;
        logic [3:0]  sy;
    } rx_word_t;

    tx_vec_t tv [11];

    function automatic logic [63:0] head_flit(input logic [3:0] dx, input logic [3:0] dy,
                                              input logic [3:0] sx, input logic [3:0] sy);
        return {1'b1, 2'b01, dx, dy, sx, sy, 45'd0};
    endfunction

    function automatic logic [63:0] data_flit(input logic last, input logic [60:0] d);
        return {1'b1, (last ? 2'b11 : 2'b10), d};
    endfunction

    function automatic logic [60:0] rand_word();
        return 61'({$urandom(), $urandom()});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b1, 61'd1, 1'b0, 1'b0, 4'd2, 4'd1, 1'b0, head_flit(4'd2, 4'd1, 4'd0, 4'd0)};
        tv[1]  = '{1'b1, 61'd1, 1'b0, 1'b0, 4'd9, 4'd9, 1'b1, data_flit(1'b0, 61'd1)};
        tv[2]  = '{1'b1, 61'd2, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 64'd0};
        tv[3]  = '{1'b1, 61'd2, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 64'd0};
        tv[4]  = '{1'b1, 61'd2, 1'b0, 1'b0, 4'd9, 4'd9, 1'b1, data_flit(1'b0, 61'd2)};
        tv[5]  = '{1'b1, 61'd3, 1'b1, 1'b0, 4'd9, 4'd9, 1'b1, data_flit(1'b1, 61'd3)};
        tv[6]  = '{1'b0, 61'd0, 1'b0, 1'b0, 4'd5, 4'd6, 1'b0, 64'd0};
        tv[7]  = '{1'b1, 61'd7, 1'b1, 1'b1, 4'd5, 4'd6, 1'b0, 64'd0};
        tv[8]  = '{1'b1, 61'd7, 1'b1, 1'b0, 4'd5, 4'd6, 1'b0, head_flit(4'd5, 4'd6, 4'd0, 4'd0)};
        tv[9]  = '{1'b1, 61'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, data_flit(1'b1, 61'd7)};
        tv[10] = '{1'b0, 61'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0};

        tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0; tx_dest_x = '0; tx_dest_y = '0;
        inj_stall = 1'b0; local_out = '0; rx_ready = 1'b0;

        // Reset state
        apply_reset(3);
        check("rst_local_in", local_in, 64'd0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_cnt", tx_pkt_cnt, 16'd0);
        check("rst_rx_cnt", rx_pkt_cnt, 16'd0);
        check("rst_overflow", rx_overflow, 1'b0);
        check("rst_err", rx_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_local_in", local_in, 64'd0);
        end

        // TX vector table: 3-word packet with a 2-cycle stall, IDLE stall, 1-word packet
        for (int i = 0; i < 11; i++) begin
            tx_valid = tv[i].valid; tx_data = tv[i].data; tx_last = tv[i].last;
            inj_stall = tv[i].stall; tx_dest_x = tv[i].dx; tx_dest_y = tv[i].dy;
            #1;
            check($sformatf("tv%0d_ready", i), tx_ready, tv[i].exp_ready);
            step();
            check($sformatf("tv%0d_flit", i), local_in, tv[i].exp_flit);
        end
        check("tv_tx_cnt", tx_pkt_cnt, 16'd2);

        // Randomized TX traffic against a flit-sequence model
        begin : tx_rand
            int          pk, wi, len, cyc;
            bit          hs;
            logic [3:0]  dx, dy;
            logic [60:0] w;
            logic        v, s, last, exp_r;
            logic [63:0] exp_f;
            pk = 0; wi = 0; hs = 1'b0; cyc = 0;
            len = $urandom_range(1, 5); dx = 4'($urandom()); dy = 4'($urandom()); w = rand_word();
            while (pk < NPK && cyc < 4000) begin
                v = ($urandom_range(0, 9) < 7);
                s = ($urandom_range(0, 9) < 2);
                last = (wi == len - 1);
                tx_valid = v; inj_stall = s; tx_data = w; tx_last = last;
                tx_dest_x = hs ? 4'($urandom()) : dx;
                tx_dest_y = hs ? 4'($urandom()) : dy;
                exp_r = hs && !s;
                exp_f = '0;
                if (!hs) begin
                    if (v && !s) begin
                        exp_f = head_flit(dx, dy, 4'd0, 4'd0);
                        hs = 1'b1;
                    end
                end else if (v && !s) begin
                    exp_f = data_flit(last, w);
                    w = rand_word();
                    wi++;
                    if (last) begin
                        hs = 1'b0; pk++; wi = 0;
                        len = $urandom_range(1, 5); dx = 4'($urandom()); dy = 4'($urandom());
                    end
                end
                #1;
                check("rand_tx_ready", tx_ready, exp_r);
                step();
                check("rand_tx_flit", local_in, exp_f);
                cyc++;
            end
            check("rand_tx_done", 64'(pk), 64'(NPK));
            check("rand_tx_cnt", tx_pkt_cnt, 16'(2 + NPK));
        end
        tx_valid = 1'b0; inj_stall = 1'b0; tx_last = 1'b0;
        step();

        // RX: HEAD(0,0 from 3,2), BODY A5, TAIL 5A
        rx_ready = 1'b0;
        local_out = head_flit(4'd0, 4'd0, 4'd3, 4'd2); step();
        check("rx1_head_err", rx_err, 1'b0);
        check("rx1_head_valid", rx_valid, 1'b0);
        local_out = data_flit(1'b0, 61'hA5); step();
        check("rx1_valid", rx_valid, 1'b1);
        check("rx1_data0", rx_data, 61'hA5);
        check("rx1_last0", rx_last, 1'b0);
        check("rx1_src", {rx_src_x, rx_src_y}, 8'h32);
        local_out = data_flit(1'b1, 61'h5A); step();
        local_out = '0;
        check("rx1_cnt", rx_pkt_cnt, 16'd1);
        rx_ready = 1'b1; step();
        check("rx1_data1", rx_data, 61'h5A);
        check("rx1_last1", rx_last, 1'b1);
        check("rx1_src1", {rx_src_x, rx_src_y}, 8'h32);
        step();
        check("rx1_empty", rx_valid, 1'b0);

        // RX overflow: 10-word packet into an 8-entry FIFO with no consumer
        rx_ready = 1'b0;
        local_out = head_flit(4'd0, 4'd0, 4'd1, 4'd1); step();
        for (int k = 1; k <= 10; k++) begin
            local_out = data_flit(k == 10, 61'(k)); step();
        end
        local_out = '0;
        check("ovf_flag", rx_overflow, 1'b1);
        check("ovf_cnt", rx_pkt_cnt, 16'd1);
        check("ovf_src", {rx_src_x, rx_src_y}, 8'h11);
        rx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf_valid%0d", k), rx_valid, 1'b1);
            check($sformatf("ovf_data%0d", k), rx_data, 61'(k));
            step();
        end
        check("ovf_drained", rx_valid, 1'b0);

        // Misrouted HEAD, discarded body, then a stray BODY in IDLE
        local_out = head_flit(4'd1, 4'd1, 4'd2, 4'd2); step();
        check("mis_err", rx_err, 1'b1);
        local_out = data_flit(1'b0, 61'h1); step();
        check("mis_err_clr", rx_err, 1'b0);
        check("mis_valid0", rx_valid, 1'b0);
        local_out = data_flit(1'b1, 61'h2); step();
        check("mis_valid1", rx_valid, 1'b0);
        local_out = data_flit(1'b0, 61'h3); step();
        check("stray_err", rx_err, 1'b1);
        check("stray_valid", rx_valid, 1'b0);
        local_out = '0; step();
        check("mis_cnt", rx_pkt_cnt, 16'd1);

        // Reset while TX is in BODY and RX is in PKT
        rx_ready = 1'b0;
        tx_valid = 1'b1; tx_dest_x = 4'd1; tx_dest_y = 4'd2; tx_data = 61'h11; tx_last = 1'b0;
        local_out = head_flit(4'd0, 4'd0, 4'd4, 4'd4); step();
        local_out = data_flit(1'b0, 61'h77); step();
        check("mr_pre_valid", rx_valid, 1'b1);
        check("mr_pre_flit", local_in, data_flit(1'b0, 61'h11));
        tx_valid = 1'b0; local_out = '0;
        apply_reset(2);
        check("mr_local_in", local_in, 64'd0);
        check("mr_tx_ready", tx_ready, 1'b0);
        check("mr_rx_valid", rx_valid, 1'b0);
        check("mr_overflow", rx_overflow, 1'b0);
        check("mr_tx_cnt", tx_pkt_cnt, 16'd0);
        check("mr_rx_cnt", rx_pkt_cnt, 16'd0);
        step();
        check("mr_no_tail", local_in, 64'd0);
        local_out = data_flit(1'b1, 61'h99); step();
        check("mr_rx_idle_err", rx_err, 1'b1);
        check("mr_rx_idle_valid", rx_valid, 1'b0);
        local_out = '0;
        tx_valid = 1'b1; tx_dest_x = 4'd3; tx_dest_y = 4'd3; tx_data = 61'h42; tx_last = 1'b1;
        #1;
        check("mr_tx_idle_ready", tx_ready, 1'b0);
        step();
        check("mr_tx_head", local_in, head_flit(4'd3, 4'd3, 4'd0, 4'd0));
        step();
        check("mr_tx_tail", local_in, data_flit(1'b1, 61'h42));
        tx_valid = 1'b0; tx_last = 1'b0;
        step();
        check("mr_tx_cnt1", tx_pkt_cnt, 16'd1);

        // Randomized RX traffic against a queue-based depacketiser model
        begin : rx_rand
            logic [63:0] fl[$];
            rx_word_t    mq[$];
            rx_word_t    nw;
            int          st, kind, len, gap;
            logic [3:0]  sx, sy, dx, dy, fdx, fdy, fsx, fsy, msx, msy;
            logic [1:0]  typ;
            logic [63:0] f;
            logic        r, ev, pop, full_b, e, movf;
            logic [15:0] mcnt;
            st = M_IDLE; msx = '0; msy = '0; movf = 1'b0; mcnt = '0;
            for (int p = 0; p < 30; p++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) fl.push_back(64'd0);
                kind = $urandom_range(0, 9);
                len  = $urandom_range(1, 6);
                sx = 4'($urandom()); sy = 4'($urandom());
                if (kind == 9) begin
                    fl.push_back(data_flit(1'b0, rand_word()));
                end else begin
                    if (kind < 7) begin
                        dx = 4'd0; dy = 4'd0;
                    end else begin
                        dx = 4'($urandom_range(1, 15)); dy = 4'($urandom());
                    end
                    fl.push_back(head_flit(dx, dy, sx, sy));
                    // kind 6: packet truncated, next HEAD arrives mid-packet
                    for (int k = 0; k < len; k++)
                        fl.push_back(data_flit((k == len - 1) && (kind != 6), rand_word()));
                end
            end
            for (int c = 0; c < fl.size() + 30; c++) begin
                f = (c < fl.size()) ? fl[c] : 64'd0;
                r = ($urandom_range(0, 9) < 6) || (c >= fl.size());
                local_out = f; rx_ready = r;
                #1;
                ev = (mq.size() != 0);
                check("rr_valid", rx_valid, ev);
                if (ev) begin
                    check("rr_data", rx_data, mq[0].d);
                    check("rr_last", rx_last, mq[0].l);
                    check("rr_src", {rx_src_x, rx_src_y}, {mq[0].sx, mq[0].sy});
                end
                pop = ev && r;
                full_b = (mq.size() == DEPTH);
                if (pop) mq.delete(0);
                e = 1'b0;
                if (f[63]) begin
                    typ = f[62:61];
                    fdx = f[60:57]; fdy = f[56:53]; fsx = f[52:49]; fsy = f[48:45];
                    case (st)
                        M_IDLE: begin
                            if (typ == 2'b01) begin
                                if (fdx == 4'd0 && fdy == 4'd0) begin
                                    st = M_PKT; msx = fsx; msy = fsy;
                                end else begin
                                    e = 1'b1; st = M_DROP;
                                end
                            end else if (typ != 2'b00) begin
                                e = 1'b1;
                            end
                        end
                        M_PKT: begin
                            if (typ == 2'b01) begin
                                e = 1'b1;
                                if (fdx == 4'd0 && fdy == 4'd0) begin
                                    msx = fsx; msy = fsy;
                                end else begin
                                    st = M_DROP;
                                end
                            end else if (typ != 2'b00) begin
                                if (!full_b || pop) begin
                                    nw = '{f[60:0], (typ == 2'b11), msx, msy};
                                    mq.push_back(nw);
                                    if (typ == 2'b11) mcnt = mcnt + 16'd1;
                                end else begin
                                    movf = 1'b1;
                                end
                                if (typ == 2'b11) st = M_IDLE;
                            end
                        end
                        default: begin
                            if (typ == 2'b11) st = M_IDLE;
                        end
                    endcase
                end
                step();
                check("rr_err", rx_err, e);
                check("rr_overflow", rx_overflow, movf);
                check("rr_cnt", rx_pkt_cnt, mcnt);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
